// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path.
//   PAR_NONE / PAR_ODD / PAR_EVEN : parity-mode values for the PARITY parameter
//   rxState_t                     : receiver FSM state encoding
//   majority3                     : 2-of-3 vote used for mid-bit sampling
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rxState_t;

   // Two-out-of-three vote, so a single noisy sample cannot flip a bit.
   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// First-word-fall-through FIFO on a single clock. The head word is always
// presented on rdData; a read simply advances the head.
//   comm_clk  : clock, rising edge
//   reset     : asynchronous active-high reset, empties the FIFO
//   wrEn      : write request for wrData
//   wrData    : word to store
//   rdEn      : consumer takes the head word (ignored while empty)
//   rdData    : head word, meaningful only while empty is low
//   empty     : no stored words
//   overflow  : one-cycle pulse after a write was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             comm_clk,
   input  logic             reset,
   input  logic             wrEn,
   input  logic [WIDTH-1:0] wrData,
   input  logic             rdEn,
   output logic [WIDTH-1:0] rdData,
   output logic             empty,
   output logic             overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wrPtr;
   logic [AW:0]      rdPtr;
   logic             full;
   logic             doWrite;
   logic             doRead;

   // Pointers carry one extra wrap bit: equal pointers mean empty, equal
   // addresses with differing wrap bits mean full.
   assign empty   = (wrPtr == rdPtr);
   assign full    = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign doRead  = rdEn && !empty;
   assign doWrite = wrEn && (!full || doRead);
   assign rdData  = mem[rdPtr[AW-1:0]];

   // Pointer bookkeeping. A write into a full FIFO is still accepted when the
   // head is leaving in the same cycle, because the freed slot is exactly the
   // one being written. Otherwise a write into a full FIFO is dropped and
   // flagged for one cycle.
   always_ff @(posedge comm_clk or posedge reset) begin
      if (reset) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         overflow <= 1'b0;
      end else begin
         if (doWrite) wrPtr <= wrPtr + PTR_ONE;
         if (doRead)  rdPtr <= rdPtr + PTR_ONE;
         overflow <= wrEn && full && !doRead;
      end
   end

   // Storage array. It needs no reset since nothing is visible until a write
   // has moved the write pointer past the slot.
   always_ff @(posedge comm_clk) begin
      if (doWrite) mem[wrPtr[AW-1:0]] <= wrData;
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// UART receiver with mid-bit majority sampling, optional parity, 1 or 2 stop
// bits, break recovery, and a small FWFT buffer for received words.
//   comm_clk   : clock, rising edge
//   reset      : asynchronous active-high reset
//   rx_serial  : asynchronous serial line, idles high
//   rx_valid   : buffer head word valid
//   rx_data    : buffer head word, LSB = first bit received
//   rx_ready   : consumer accepts the head word
//   frame_err  : one-cycle pulse on a bad stop bit
//   parity_err : one-cycle pulse on a parity mismatch
//   overflow   : one-cycle pulse when a good word was dropped (buffer full)
// ---------------------------------------------------------------------------
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                 comm_clk,
   input  logic                 reset,
   input  logic                 rx_serial,
   output logic                 rx_valid,
   output logic [DATA_BITS-1:0] rx_data,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overflow
);

   localparam int CW = $clog2(CLK_PER_BIT);
   localparam int IW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_S0   = CW'(CLK_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] CNT_S1   = CW'(CLK_PER_BIT / 2);
   localparam logic [CW-1:0] CNT_S2   = CW'(CLK_PER_BIT / 2 + 1);
   localparam logic [IW-1:0] IDX_ONE  = IW'(1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

   rxState_t             state;
   rxState_t             stateNext;
   logic                 syncMeta;
   logic                 syncLine;
   logic                 lineLast;
   logic [CW-1:0]        bitCnt;
   logic [CW-1:0]        bitCntNext;
   logic [IW-1:0]        bitIdx;
   logic [IW-1:0]        bitIdxNext;
   logic                 stopIdx;
   logic                 stopIdxNext;
   logic [DATA_BITS-1:0] shiftReg;
   logic [DATA_BITS-1:0] shiftNext;
   logic                 parityBad;
   logic                 parityBadNext;
   logic                 frameErrNext;
   logic                 parityErrNext;
   logic                 pushWord;
   logic                 sampA;
   logic                 sampB;
   logic                 voted;
   logic                 atVote;
   logic                 atEnd;
   logic                 parityExpected;
   logic                 fifoEmpty;

   // The serial line is asynchronous, so it goes through two flops before any
   // logic looks at it. A third flop keeps the previous synchronised value so
   // a falling edge can be seen. All three reset high, matching an idle line,
   // so a frame interrupted by reset is never mistaken for a new start.
   always_ff @(posedge comm_clk or posedge reset) begin
      if (reset) begin
         syncMeta <= 1'b1;
         syncLine <= 1'b1;
         lineLast <= 1'b1;
      end else begin
         syncMeta <= rx_serial;
         syncLine <= syncMeta;
         lineLast <= syncLine;
      end
   end

   // The first two of the three mid-bit samples are stored here. The third
   // is the live synchronised value at the vote point.
   assign voted  = majority3(sampA, sampB, syncLine);
   assign atVote = (bitCnt == CNT_S2);
   assign atEnd  = (bitCnt == CNT_LAST);

   assign parityExpected = (PARITY == PAR_ODD) ? ~(^shiftReg) : ^shiftReg;

   // State register for the receive FSM.
   always_ff @(posedge comm_clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= stateNext;
   end

   // Next-state and datapath control. Each bit is decided at the vote point
   // in the middle of the bit. Most states only move on at the end of the
   // bit time, but two cases move at the vote point. A bad stop bit goes to
   // BREAK at once. A good final stop bit writes the word and goes back to
   // IDLE at once, so the next start edge can arrive while the stop bit is
   // still on the line. A parity failure is remembered until the stop bit so
   // the word can be dropped while the framing check still runs.
   always_comb begin
      stateNext     = state;
      bitCntNext    = atEnd ? '0 : bitCnt + CNT_ONE;
      bitIdxNext    = bitIdx;
      stopIdxNext   = stopIdx;
      shiftNext     = shiftReg;
      parityBadNext = parityBad;
      frameErrNext  = 1'b0;
      parityErrNext = 1'b0;
      pushWord      = 1'b0;
      case (state)
         ST_IDLE: begin
            bitCntNext    = '0;
            bitIdxNext    = '0;
            stopIdxNext   = 1'b0;
            parityBadNext = 1'b0;
            if (lineLast && !syncLine) stateNext = ST_START;
         end
         ST_START: begin
            if (atVote && voted) stateNext = ST_IDLE;
            else if (atEnd)      stateNext = ST_DATA;
         end
         ST_DATA: begin
            if (atVote) shiftNext = {voted, shiftReg[DATA_BITS-1:1]};
            if (atEnd) begin
               if (bitIdx == IDX_LAST) begin
                  bitIdxNext = '0;
                  stateNext  = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
               end else begin
                  bitIdxNext = bitIdx + IDX_ONE;
               end
            end
         end
         ST_PARITY: begin
            if (atVote && (voted != parityExpected)) begin
               parityBadNext = 1'b1;
               parityErrNext = 1'b1;
            end
            if (atEnd) stateNext = ST_STOP;
         end
         ST_STOP: begin
            if (atVote) begin
               if (!voted) begin
                  frameErrNext = 1'b1;
                  stateNext    = ST_BREAK;
                  bitCntNext   = '0;
               end else if (stopIdx == STOP_LAST) begin
                  pushWord   = !parityBad;
                  stateNext  = ST_IDLE;
                  bitCntNext = '0;
               end
            end
            if (atEnd) stopIdxNext = 1'b1;
         end
         ST_BREAK: begin
            if (!syncLine) begin
               bitCntNext = '0;
            end else if (atEnd) begin
               stateNext  = ST_IDLE;
               bitCntNext = '0;
            end
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   // Datapath registers driven by the FSM decisions above. The error pulses
   // are registered so they are clean single-cycle strobes.
   always_ff @(posedge comm_clk or posedge reset) begin
      if (reset) begin
         bitCnt     <= '0;
         bitIdx     <= '0;
         stopIdx    <= 1'b0;
         shiftReg   <= '0;
         parityBad  <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         sampA      <= 1'b1;
         sampB      <= 1'b1;
      end else begin
         bitCnt     <= bitCntNext;
         bitIdx     <= bitIdxNext;
         stopIdx    <= stopIdxNext;
         shiftReg   <= shiftNext;
         parityBad  <= parityBadNext;
         frame_err  <= frameErrNext;
         parity_err <= parityErrNext;
         if (bitCnt == CNT_S0) sampA <= syncLine;
         if (bitCnt == CNT_S1) sampB <= syncLine;
      end
   end

   // Received-word buffer. Good words are written at the final stop-bit vote
   // and the consumer drains them with a valid/ready handshake.
   sync_fifo #(
      .WIDTH(DATA_BITS),
      .DEPTH(FIFO_DEPTH)
   ) rxFifo (
      .comm_clk (comm_clk),
      .reset    (reset),
      .wrEn     (pushWord),
      .wrData   (shiftReg),
      .rdEn     (rx_ready),
      .rdData   (rx_data),
      .empty    (fifoEmpty),
      .overflow (overflow)
   );

   assign rx_valid = !fifoEmpty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Scoreboard bench for uart_rx_fifo. Two instances are exercised:
//   dut0 : default parameters (16 clocks/bit, 8 data bits, no parity, 1 stop, depth 4)
//   dut1 : 8 clocks/bit, even parity, 2 stop bits, depth 2
// The stimulus task predicts each frame's outcome from the frame's contents
// and pushes expected words into a per-instance queue. Monitors pop and
// compare on every handshake and count the error pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

   localparam int BIT0   = 16;
   localparam int BIT1   = 8;
   localparam int DEPTH0 = 4;
   localparam int DEPTH1 = 2;

   logic       clock;
   logic       reset;
   logic       serial0, serial1;
   logic       ready0, ready1;
   logic       valid0, valid1;
   logic [7:0] data0, data1;
   logic       frameErr0, frameErr1;
   logic       parityErr0, parityErr1;
   logic       overflow0, overflow1;

   int checks   = 0;
   int failures = 0;
   int readyMode = 1;
   int expFrame[2], expParity[2], expOverflow[2];
   int gotFrame[2], gotParity[2], gotOverflow[2];
   logic [7:0] exp0[$];
   logic [7:0] exp1[$];
   logic       holdPrev0, holdPrev1;
   logic [7:0] dataPrev0, dataPrev1;

   uart_rx_fifo dut0 (
      .comm_clk   (clock),
      .reset      (reset),
      .rx_serial  (serial0),
      .rx_valid   (valid0),
      .rx_data    (data0),
      .rx_ready   (ready0),
      .frame_err  (frameErr0),
      .parity_err (parityErr0),
      .overflow   (overflow0)
   );

   uart_rx_fifo #(
      .CLK_PER_BIT (BIT1),
      .DATA_BITS   (8),
      .PARITY      (2),
      .STOP_BITS   (2),
      .FIFO_DEPTH  (DEPTH1)
   ) dut1 (
      .comm_clk   (clock),
      .reset      (reset),
      .rx_serial  (serial1),
      .rx_valid   (valid1),
      .rx_data    (data1),
      .rx_ready   (ready1),
      .frame_err  (frameErr1),
      .parity_err (parityErr1),
      .overflow   (overflow1)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something hangs outside the bounded waits.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog expired got=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   // Consumer ready: held low, held high, or random each cycle.
   initial begin
      ready0 = 1'b1;
      ready1 = 1'b1;
      forever begin
         @(posedge clock);
         #2;
         if (readyMode == 2) begin
            ready0 = 1'($urandom % 2);
            ready1 = 1'($urandom % 2);
         end else begin
            ready0 = (readyMode == 1);
            ready1 = (readyMode == 1);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expected);
      checks++;
      if (got !== expected) begin
         failures++;
         $display("[TB] FAIL %s got=%0d expected=%0d", name, got, expected);
      end
   endtask

   // Drive one line for a number of cycles; always leaves us 2 ns after a posedge.
   task automatic holdLine(input int which, input logic val, input int cycles);
      if (which == 0) serial0 = val;
      else            serial1 = val;
      repeat (cycles) @(posedge clock);
      #2;
   endtask

   // Send one frame and predict its outcome.
   // badStop: 0 good, 1 first stop bit low, 2 second stop bit low (dut1 only).
   // lowBits: extra bit times the line stays low after a bad stop bit.
   task automatic applyStimulus(input int which, input logic [7:0] data, input logic parBit,
                                input int badStop, input int lowBits, input int idle);
      int   bc;
      logic parOk;
      bc    = (which == 0) ? BIT0 : BIT1;
      parOk = (which == 0) || (parBit == logic'($countones(data) % 2));
      if (!parOk)       expParity[which]++;
      if (badStop != 0) expFrame[which]++;
      if (parOk && badStop == 0) begin
         if (which == 0) begin
            if (exp0.size() >= DEPTH0) expOverflow[0]++;
            else exp0.push_back(data);
         end else begin
            if (exp1.size() >= DEPTH1) expOverflow[1]++;
            else exp1.push_back(data);
         end
      end
      holdLine(which, 1'b0, bc);
      for (int i = 0; i < 8; i++) holdLine(which, data[i], bc);
      if (which == 1) holdLine(1, parBit, bc);
      if (which == 0) begin
         holdLine(0, logic'(badStop == 0), bc);
      end else begin
         holdLine(1, logic'(badStop != 1), bc);
         holdLine(1, logic'(badStop != 2), bc);
      end
      if (lowBits > 0) holdLine(which, 1'b0, lowBits * bc);
      holdLine(which, 1'b1, idle);
   endtask

   task automatic checkCounts(input int which, input string tag);
      checkOutput($sformatf("%s dut%0d frame_err pulses", tag, which), gotFrame[which], expFrame[which]);
      checkOutput($sformatf("%s dut%0d parity_err pulses", tag, which), gotParity[which], expParity[which]);
      checkOutput($sformatf("%s dut%0d overflow pulses", tag, which), gotOverflow[which], expOverflow[which]);
   endtask

   // Wait (bounded) until every expected word came out and both buffers are empty.
   task automatic waitDrain(input string tag, input int limit);
      int n;
      n = 0;
      while ((exp0.size() != 0 || exp1.size() != 0 || valid0 || valid1) && n < limit) begin
         @(posedge clock);
         #2;
         n++;
      end
      checkOutput({tag, " dut0 words outstanding"}, exp0.size(), 0);
      checkOutput({tag, " dut1 words outstanding"}, exp1.size(), 0);
      checkOutput({tag, " dut0 rx_valid after drain"}, valid0, 0);
      checkOutput({tag, " dut1 rx_valid after drain"}, valid1, 0);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, " dut0 rx_valid"}, valid0, 0);
      checkOutput({tag, " dut0 frame_err"}, frameErr0, 0);
      checkOutput({tag, " dut0 parity_err"}, parityErr0, 0);
      checkOutput({tag, " dut0 overflow"}, overflow0, 0);
      checkOutput({tag, " dut1 rx_valid"}, valid1, 0);
      checkOutput({tag, " dut1 frame_err"}, frameErr1, 0);
      checkOutput({tag, " dut1 parity_err"}, parityErr1, 0);
      checkOutput({tag, " dut1 overflow"}, overflow1, 0);
   endtask

   // Monitor for dut0: scoreboard pop on handshake, hold-stability, pulse counts.
   always @(negedge clock) begin
      logic [7:0] expWord;
      if (reset) begin
         holdPrev0 = 1'b0;
      end else begin
         if (frameErr0)  gotFrame[0]++;
         if (parityErr0) gotParity[0]++;
         if (overflow0)  gotOverflow[0]++;
         if (holdPrev0) checkOutput("dut0 rx_data held while stalled", data0, dataPrev0);
         if (valid0 && ready0) begin
            checks++;
            if (exp0.size() == 0) begin
               failures++;
               $display("[TB] FAIL dut0 unexpected word got=%h expected=none", data0);
            end else begin
               expWord = exp0.pop_front();
               if (data0 !== expWord) begin
                  failures++;
                  $display("[TB] FAIL dut0 rx_data got=%h expected=%h", data0, expWord);
               end
            end
         end
         holdPrev0 = valid0 && !ready0;
         dataPrev0 = data0;
      end
   end

   // Monitor for dut1, same checks.
   always @(negedge clock) begin
      logic [7:0] expWord;
      if (reset) begin
         holdPrev1 = 1'b0;
      end else begin
         if (frameErr1)  gotFrame[1]++;
         if (parityErr1) gotParity[1]++;
         if (overflow1)  gotOverflow[1]++;
         if (holdPrev1) checkOutput("dut1 rx_data held while stalled", data1, dataPrev1);
         if (valid1 && ready1) begin
            checks++;
            if (exp1.size() == 0) begin
               failures++;
               $display("[TB] FAIL dut1 unexpected word got=%h expected=none", data1);
            end else begin
               expWord = exp1.pop_front();
               if (data1 !== expWord) begin
                  failures++;
                  $display("[TB] FAIL dut1 rx_data got=%h expected=%h", data1, expWord);
               end
            end
         end
         holdPrev1 = valid1 && !ready1;
         dataPrev1 = data1;
      end
   end

   initial begin
      for (int i = 0; i < 2; i++) begin
         expFrame[i] = 0; expParity[i] = 0; expOverflow[i] = 0;
         gotFrame[i] = 0; gotParity[i] = 0; gotOverflow[i] = 0;
      end
      serial0 = 1'b1;
      serial1 = 1'b1;
      reset   = 1'b1;
      repeat (3) @(posedge clock);
      #2;
      checkIdleOutputs("reset");
      reset = 1'b0;
      holdLine(0, 1'b1, 5);

      $display("[TB] single clean frame 0x55");
      applyStimulus(0, 8'h55, 1'b0, 0, 0, 20);
      waitDrain("clean 0x55", 100);
      checkCounts(0, "clean 0x55");

      $display("[TB] even parity, good then bad parity bit");
      applyStimulus(1, 8'h41, 1'b0, 0, 0, 10);
      waitDrain("parity good", 100);
      checkCounts(1, "parity good");
      applyStimulus(1, 8'h41, 1'b1, 0, 0, 10);
      waitDrain("parity bad", 100);
      checkCounts(1, "parity bad");

      $display("[TB] false start then 0xA3");
      holdLine(0, 1'b0, 4);
      holdLine(0, 1'b1, 30);
      waitDrain("false start", 50);
      checkCounts(0, "false start");
      applyStimulus(0, 8'hA3, 1'b0, 0, 0, 20);
      waitDrain("after false start", 100);
      checkCounts(0, "after false start");

      $display("[TB] framing error with held break, then 0x12");
      applyStimulus(0, 8'h7E, 1'b0, 1, 3, 40);
      waitDrain("framing", 100);
      checkCounts(0, "framing");
      applyStimulus(0, 8'h12, 1'b0, 0, 0, 20);
      waitDrain("after break", 100);
      checkCounts(0, "after break");

      $display("[TB] overflow with consumer stalled");
      readyMode = 0;
      holdLine(0, 1'b1, 4);
      for (int i = 1; i <= 5; i++) applyStimulus(0, 8'(i), 1'b0, 0, 0, 4);
      holdLine(0, 1'b1, 5);
      checkOutput("overflow dut0 rx_valid while stalled", valid0, 1);
      checkCounts(0, "overflow stalled");
      readyMode = 1;
      waitDrain("overflow drain", 200);
      checkCounts(0, "overflow drained");

      $display("[TB] reset in the middle of a frame");
      holdLine(0, 1'b0, BIT0);
      holdLine(0, 1'b1, BIT0 * 3 + BIT0 / 2);
      reset = 1'b1;
      holdLine(0, 1'b1, 3);
      checkIdleOutputs("mid-frame reset");
      reset = 1'b0;
      holdLine(0, 1'b1, BIT0 * 6);
      checkIdleOutputs("after mid-frame reset");
      applyStimulus(0, 8'h3C, 1'b0, 0, 0, 20);
      waitDrain("after reset 0x3C", 100);
      checkCounts(0, "after reset 0x3C");

      $display("[TB] randomized frames");
      readyMode = 2;
      for (int n = 0; n < 30; n++) begin
         int         which;
         int         badStop;
         int         lowBits;
         int         idle;
         int         bc;
         logic [7:0] d;
         logic       pb;
         which   = int'($urandom % 2);
         bc      = (which == 0) ? BIT0 : BIT1;
         d       = 8'($urandom);
         pb      = logic'($countones(d) % 2);
         if ($urandom % 5 == 0) pb = ~pb;
         badStop = 0;
         lowBits = 0;
         if ($urandom % 6 == 0) begin
            badStop = (which == 1) ? int'(1 + $urandom % 2) : 1;
            lowBits = int'($urandom % 3);
         end
         idle = (badStop != 0) ? 2 * bc + int'($urandom % 10) : 1 + int'($urandom % 10);
         applyStimulus(which, d, pb, badStop, lowBits, idle);
      end
      waitDrain("random", 300);
      checkCounts(0, "random");
      checkCounts(1, "random");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_PER_BIT, default 16: comm_clk cycles per serial bit; legal values are 8 or more.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-004 SHALL have parameter STOP_BITS, default 1: stop bits checked per frame; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: received-word buffer entries; must be a power of 2, 2 or more.
REQ-006 SHALL have port comm_clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port rx_serial, input, 1 bit: asynchronous serial line, idles high.
REQ-009 SHALL have port rx_valid, output, 1 bit: FIFO head word is valid.
REQ-010 SHALL have port rx_data, output, DATA_BITS: FIFO head word, LSB = first bit received.
REQ-011 SHALL have port rx_ready, input, 1 bit: consumer accepts the head word.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-013 SHALL have port parity_err, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-014 SHALL have port overflow, output, 1 bit: one-cycle pulse when a good word is dropped because the FIFO is full.

Function
REQ-015 SHALL pass rx_serial through a 2-flop synchroniser; all logic below uses the synchronised value.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, BREAK with a bit-timing counter and a bit index.
REQ-017 IDLE SHALL move to START on a synchronised 1-to-0 transition and restart the bit counter.
REQ-018 Each bit SHALL be sampled as the majority of 3 samples taken at counter values CLK_PER_BIT/2-1, CLK_PER_BIT/2 and CLK_PER_BIT/2+1.
REQ-019 START SHALL return to IDLE if the sampled start bit is 1 (false start); no flag is raised.
REQ-020 DATA SHALL shift in DATA_BITS bits, LSB first, one bit per CLK_PER_BIT cycles.
REQ-021 PARITY (entered only when PARITY != 0) SHALL compare the sampled bit with odd or even parity of the data bits.
REQ-022 STOP SHALL sample STOP_BITS bits; any sampled 0 raises frame_err once and moves the FSM to BREAK.
REQ-023 BREAK SHALL wait for the synchronised line to be high for one full bit time, then enter IDLE.
REQ-024 A word with a parity or framing error SHALL be discarded, not written to the FIFO; if both errors occur, both pulses SHALL be raised.
REQ-025 After a good final stop sample, the word SHALL be written to the FIFO and the FSM SHALL return to IDLE in the same cycle, so a start edge is accepted in the next cycle.
REQ-026 rx_valid SHALL rise on the cycle after that FIFO write when the FIFO was empty (FIFO latency 1 cycle).
REQ-027 The FIFO SHALL be first-word-fall-through: rx_valid = not empty, and a pop occurs when rx_valid and rx_ready are both high.
REQ-028 A write when the FIFO is full SHALL drop the new word and pulse overflow; stored words SHALL be untouched.
REQ-029 A simultaneous push and pop when the FIFO is full SHALL succeed without overflow; when empty, the push SHALL be stored and rx_valid SHALL rise on the next cycle.
REQ-030 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full = MSBs differ and the rest are equal.
REQ-031 rx_data SHALL be held stable while rx_valid is high and rx_ready is low.

Reset
REQ-032 Reset SHALL force FSM = IDLE, counters = 0, FIFO empty, and synchroniser flops = 1.
REQ-033 Reset SHALL force rx_valid, frame_err, parity_err and overflow to 0; rx_data is don't-care while rx_valid is 0.
REQ-034 Reset asserted mid-frame SHALL abandon the partial word; after release, a frame SHALL be received only from a new falling edge.

Structure
REQ-035 A shared package uart_pkg SHALL hold the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the FSM state encoding.
REQ-036 The FIFO SHALL be a sub-module named sync_fifo, parametrised in WIDTH and DEPTH, on the same comm_clk and reset.

Verification
REQ-037 Defaults, frame 0x55 with 1 stop bit, rx_ready = 1 -> one rx_valid cycle with rx_data = 0x55 and no error pulses.
REQ-038 PARITY = 2, frames 0x41 with parity bit 0 and then with parity bit 1 -> 0x41 delivered once; parity_err pulses once, for the second frame only.
REQ-039 Line low for 4 cycles, then high -> no rx_valid, no error pulses; a following 0xA3 frame is received correctly.
REQ-040 Frame 0x7E with stop bit 0, line then held low 3 bit times -> frame_err pulses once, no word is stored, and 0x12 after line release is received correctly.
REQ-041 rx_ready = 0, five frames 0x01..0x05 -> overflow pulses once, on the 5th; with rx_ready = 1, 0x01..0x04 come out in order and rx_valid then drops.
REQ-042 Reset pulsed during data bit 3 of 0xFF -> all outputs 0; a following 0x3C frame is received correctly with no error pulses.
